// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a small combinational gate.
// It walks every input vector in ascending order, holds each for DWELL cycles, then samples and scores the gate output.
module gate_bist_ctrl #(
    parameter int N_IN = 2,
    parameter int DWELL = 4,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            gate_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] fail_idx
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] LAST_IDX   = N_IN'((1 << N_IN) - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] idx;
    logic [DW-1:0]   dwell_cnt;
    logic            first_seen;
    logic [N_IN-1:0] vec_q;
    logic            sample;
    logic            last;
    logic            mismatch;
    logic [N_IN:0]   fail_cnt_next;

    assign sample        = (state == APPLY) && (dwell_cnt == DWELL_LAST);
    assign last          = (idx == LAST_IDX);
    assign mismatch      = (gate_y != EXPECT[idx]);
    assign fail_cnt_next = fail_cnt + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = APPLY;
            APPLY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sample && last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == APPLY);
        done    = (state == DONE);
        vec_out = vec_q;
    end

    // Abort wins over the sample/advance action; the partial score is kept but pass stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            dwell_cnt  <= '0;
            first_seen <= 1'b0;
            vec_q      <= '0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            fail_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        dwell_cnt  <= '0;
                        first_seen <= 1'b0;
                        vec_q      <= '0;
                        pass       <= 1'b0;
                        fail_cnt   <= '0;
                        fail_idx   <= '0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        vec_q <= '0;
                        pass  <= 1'b0;
                    end else if (sample) begin
                        fail_cnt  <= fail_cnt_next;
                        dwell_cnt <= '0;
                        if (mismatch && !first_seen) begin
                            fail_idx   <= idx;
                            first_seen <= 1'b1;
                        end
                        if (last) begin
                            vec_q <= '0;
                            pass  <= (fail_cnt_next == '0);
                        end else begin
                            idx   <= idx + 1'b1;
                            vec_q <= idx + 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
